// File: rtl/minmax_stream.sv
// ---------------------------------------------------------------------------
// minmax_stream
//   Streaming min/max finder. Values arrive one per accepted beat on a
//   valid/ready input. When a frame closes, the block presents the frame's
//   min or max on a valid/ready output, together with the winner's in-frame
//   position and the number of beats in the frame. A frame closes on the beat
//   carrying in_last, or on the NI-th beat, whichever comes first.
//
// Parameters
//   W        data width
//   NI       max beats per frame (>= 2)
//   IDXW     index width
//   OUT_CFG  0 = value + index, 1 = value only (out_index tied to 0)
//   MM_CFG   0 = min/max chosen per frame by min_max_sel, 1 = min, 2 = max
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   min_max_sel  0 = min, 1 = max; sampled on the first beat (MM_CFG = 0)
//   in_valid     input beat valid
//   in_ready     block can accept a beat
//   in_data      input value
//   in_last      final beat of the frame
//   out_valid    result valid
//   out_ready    downstream accepts the result
//   out_result   frame min/max
//   out_index    0-based beat position of the winner
//   out_count    beats in the frame (1..NI)
// ---------------------------------------------------------------------------
module minmax_stream #(
  parameter int W       = 5,
  parameter int NI      = 64,
  parameter int IDXW    = $clog2(NI),
  parameter int OUT_CFG = 1,
  parameter int MM_CFG  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            min_max_sel,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_result,
  output logic [IDXW-1:0] out_index,
  output logic [IDXW:0]   out_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [IDXW:0] CNT_ONE = (IDXW+1)'(1);
  localparam logic [IDXW:0] CNT_MAX = (IDXW+1)'(NI);

  logic [1:0]    state;
  logic [W-1:0]  best;      // running winner of the open frame
  logic [IDXW:0] cnt;       // beats accepted so far in the open frame
  logic          sel_q;     // min_max_sel latched on the first beat

  logic          beat;
  logic          first;
  logic          eff_sel;
  logic          replace;
  logic          close;
  logic [W-1:0]  nxt_best;
  logic [IDXW:0] nxt_cnt;

  assign in_ready  = (state != S_HOLD);
  assign out_valid = (state == S_HOLD);
  assign beat      = in_valid & in_ready;
  assign first     = (state == S_IDLE);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    eff_sel  = sel_q;
    replace  = 1'b1;
    if (MM_CFG == 1)      eff_sel = 1'b0;
    else if (MM_CFG == 2) eff_sel = 1'b1;
    else if (first)       eff_sel = min_max_sel;

    // Strict compare keeps the earlier beat on a tie.
    if (!first) replace = eff_sel ? (in_data > best) : (in_data < best);

    nxt_best = replace ? in_data : best;
    nxt_cnt  = first ? CNT_ONE : cnt + CNT_ONE;
    close    = in_last | (nxt_cnt == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset as well, because the outputs
    // must read 0 after reset, not just after the first frame.
    if (rst) begin
      state      <= S_IDLE;
      best       <= '0;
      cnt        <= '0;
      sel_q      <= 1'b0;
      out_result <= '0;
      out_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      case (state)
        S_IDLE, S_ACC: begin
          if (beat) begin
            best <= nxt_best;
            cnt  <= nxt_cnt;
            if (first) sel_q <= min_max_sel;
            if (close) begin
              state      <= S_HOLD;
              out_result <= nxt_best;
              out_count  <= nxt_cnt;
            end else begin
              state <= S_ACC;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  if (OUT_CFG == 0) begin : g_index
    logic [IDXW-1:0] best_idx;
    logic [IDXW-1:0] nxt_idx;

    // The incoming beat's position equals the count before it; cnt < NI here.
    always_comb begin
      nxt_idx = best_idx;
      if (first)        nxt_idx = '0;
      else if (replace) nxt_idx = cnt[IDXW-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        best_idx  <= '0;
        out_index <= '0;
      end else if (beat) begin
        best_idx <= nxt_idx;
        if (close) out_index <= nxt_idx;
      end
    end
  end else begin : g_no_index
    assign out_index = '0;
  end

endmodule

// File: tb/tb_minmax_stream.sv
// ---------------------------------------------------------------------------
// tb_minmax_stream
//   Three minmax_stream instances share one stimulus stream:
//     A: NI=8,  OUT_CFG=0, MM_CFG=0  (per-frame min/max, index reported)
//     B: NI=8,  OUT_CFG=1, MM_CFG=2  (max only, no index)
//     C: NI=64, OUT_CFG=1, MM_CFG=1  (defaults, min only)
//   Each instance has its own frame model: accepted values are stored in an
//   array and, on close, the extremum and the first position holding it are
//   found by plain search. A negedge process compares every instance against
//   its model each cycle; directed scenarios also pin literal values.
// ---------------------------------------------------------------------------
module tb_minmax_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       min_max_sel;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       a_in_ready, a_out_valid;
  logic [4:0] a_out_result;
  logic [2:0] a_out_index;
  logic [3:0] a_out_count;

  logic       b_in_ready, b_out_valid;
  logic [4:0] b_out_result;
  logic [2:0] b_out_index;
  logic [3:0] b_out_count;

  logic       c_in_ready, c_out_valid;
  logic [4:0] c_out_result;
  logic [5:0] c_out_index;
  logic [6:0] c_out_count;

  always #5 clk = ~clk;

  minmax_stream #(.W(5), .NI(8), .OUT_CFG(0), .MM_CFG(0)) u_a (
    .clk(clk), .rst(rst), .min_max_sel(min_max_sel),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_result(a_out_result), .out_index(a_out_index), .out_count(a_out_count));

  minmax_stream #(.W(5), .NI(8), .OUT_CFG(1), .MM_CFG(2)) u_b (
    .clk(clk), .rst(rst), .min_max_sel(min_max_sel),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_result(b_out_result), .out_index(b_out_index), .out_count(b_out_count));

  minmax_stream u_c (
    .clk(clk), .rst(rst), .min_max_sel(min_max_sel),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(c_out_valid), .out_ready(out_ready),
    .out_result(c_out_result), .out_index(c_out_index), .out_count(c_out_count));

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;
  bit rand_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural frame model ----------------
  int ni_k[3]   = '{8, 8, 64};
  int ocfg_k[3] = '{0, 1, 1};
  int mcfg_k[3] = '{0, 2, 1};

  int m_buf[3][64];
  int m_n[3];
  bit m_sel[3];
  bit m_hold[3];
  bit m_defined[3];   // outputs are specified (zero) since reset
  int m_res[3];
  int m_idx[3];
  int m_cnt[3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_n[k] = 0; m_sel[k] = 0; m_hold[k] = 0; m_defined[k] = 0;
      m_res[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
    end
  end

  task automatic model_close(input int k);
    int ext;
    int pos;
    ext = m_buf[k][0];
    for (int i = 1; i < m_n[k]; i++)
      if (m_sel[k] ? (m_buf[k][i] > ext) : (m_buf[k][i] < ext)) ext = m_buf[k][i];
    pos = 0;
    for (int i = m_n[k] - 1; i >= 0; i--)
      if (m_buf[k][i] == ext) pos = i;
    m_res[k]     = ext;
    m_idx[k]     = (ocfg_k[k] == 0) ? pos : 0;
    m_cnt[k]     = m_n[k];
    m_hold[k]    = 1'b1;
    m_defined[k] = 1'b0;
    m_n[k]       = 0;
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_hold[k] = 0; m_n[k] = 0; m_defined[k] = 1;
        m_res[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
      end else if (m_hold[k]) begin
        if (out_ready) m_hold[k] = 0;
      end else if (in_valid) begin
        if (m_n[k] == 0)
          m_sel[k] = (mcfg_k[k] == 1) ? 1'b0 : (mcfg_k[k] == 2) ? 1'b1 : min_max_sel;
        m_buf[k][m_n[k]] = int'(in_data);
        m_n[k]++;
        if (in_last || m_n[k] == ni_k[k]) model_close(k);
      end
    end
  end

  task automatic cmp(input int k, input string nm, input logic ov, input logic ir,
                     input logic [31:0] res, input logic [31:0] idx, input logic [31:0] cnt);
    check({nm, " out_valid"}, {31'b0, ov}, {31'b0, m_hold[k]});
    check({nm, " in_ready"},  {31'b0, ir}, {31'b0, !m_hold[k]});
    if (m_hold[k] || m_defined[k]) begin
      check({nm, " out_result"}, res, m_res[k]);
      check({nm, " out_index"},  idx, m_idx[k]);
      check({nm, " out_count"},  cnt, m_cnt[k]);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp(0, "A", a_out_valid, a_in_ready, a_out_result, a_out_index, a_out_count);
      cmp(1, "B", b_out_valid, b_in_ready, b_out_result, b_out_index, b_out_count);
      cmp(2, "C", c_out_valid, c_in_ready, c_out_result, c_out_index, c_out_count);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    if (rand_rdy) out_ready = ($urandom_range(3) != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Offer one beat; it is held until instance A accepts it.
  task automatic send_beat(input logic [4:0] d, input logic last, input logic sel);
    int waited;
    in_data = d; in_last = last; min_max_sel = sel; in_valid = 1'b1;
    waited = 0;
    while (!a_in_ready && waited < 100) begin
      step();
      waited++;
    end
    if (waited >= 100) check("beat accept timeout", 32'd0, 32'd1);
    if (rand_rdy) out_ready = ($urandom_range(3) != 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'($urandom_range(1));
    in_data  = 5'($urandom_range(31));
  endtask

  task automatic send_frame5(input logic s0, input logic s1, input logic s2);
    send_beat(5'd7,  1'b0, s0);
    send_beat(5'd3,  1'b0, s1);
    send_beat(5'd9,  1'b0, s2);
    send_beat(5'd3,  1'b0, s2);
    send_beat(5'd12, 1'b1, s2);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    min_max_sel = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cmp_en = 1'b1;
    check("reset out_valid",  {31'b0, a_out_valid}, 32'd0);
    check("reset in_ready",   {31'b0, a_in_ready},  32'd1);
    check("reset out_result", a_out_result, 32'd0);
    check("reset out_count",  c_out_count,  32'd0);

    // Min frame: 7,3,9,3,12 -> 3 at index 1 (tie at 3 keeps the earlier).
    send_frame5(1'b0, 1'b0, 1'b0);
    check("t1 A out_valid",  {31'b0, a_out_valid}, 32'd1);
    check("t1 A out_result", a_out_result, 32'd3);
    check("t1 A out_index",  a_out_index,  32'd1);
    check("t1 A out_count",  a_out_count,  32'd5);
    check("t1 B out_result", b_out_result, 32'd12);
    check("t1 C out_result", c_out_result, 32'd3);
    idle(2);

    // Max frame, sel dropped to 0 from beat 3 onward: still max.
    send_frame5(1'b1, 1'b1, 1'b0);
    check("t2 A out_result", a_out_result, 32'd12);
    check("t2 A out_index",  a_out_index,  32'd4);
    check("t2 A out_count",  a_out_count,  32'd5);
    idle(2);

    // 1..8 without in_last: A and B auto-close at 8, C keeps accumulating.
    for (int v = 1; v <= 8; v++) send_beat(5'(v), 1'b0, 1'b1);
    check("t3 A out_valid",  {31'b0, a_out_valid}, 32'd1);
    check("t3 A out_result", a_out_result, 32'd8);
    check("t3 A out_index",  a_out_index,  32'd7);
    check("t3 A out_count",  a_out_count,  32'd8);
    check("t3 B out_result", b_out_result, 32'd8);
    check("t3 B out_count",  b_out_count,  32'd8);
    check("t3 C out_valid",  {31'b0, c_out_valid}, 32'd0);
    send_beat(5'd20, 1'b1, 1'b1);
    check("t3 A new frame result", a_out_result, 32'd20);
    check("t3 A new frame count",  a_out_count,  32'd1);
    check("t3 C out_result", c_out_result, 32'd1);
    check("t3 C out_count",  c_out_count,  32'd9);
    idle(2);

    // Backpressure in HOLD.
    out_ready = 1'b0;
    send_beat(5'd6, 1'b0, 1'b0);
    send_beat(5'd2, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("t4 hold out_valid",  {31'b0, a_out_valid}, 32'd1);
      check("t4 hold in_ready",   {31'b0, a_in_ready},  32'd0);
      check("t4 hold out_result", a_out_result, 32'd2);
      check("t4 hold out_index",  a_out_index,  32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4 release in_ready",  {31'b0, a_in_ready},  32'd1);
    check("t4 release out_valid", {31'b0, a_out_valid}, 32'd0);
    idle(1);

    // Reset mid-frame discards it.
    send_beat(5'd10, 1'b0, 1'b1);
    send_beat(5'd11, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5 rst out_valid",  {31'b0, a_out_valid}, 32'd0);
    check("t5 rst out_result", a_out_result, 32'd0);
    check("t5 rst out_index",  a_out_index,  32'd0);
    check("t5 rst out_count",  a_out_count,  32'd0);
    send_beat(5'd5, 1'b1, 1'b0);
    check("t5 A out_result", a_out_result, 32'd5);
    check("t5 A out_index",  a_out_index,  32'd0);
    check("t5 A out_count",  a_out_count,  32'd1);
    check("t5 C out_count",  c_out_count,  32'd1);
    idle(2);

    // All-equal frames in min then max mode.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) send_beat(5'd4, (i == 3), 1'(m));
      check("t6 A out_result", a_out_result, 32'd4);
      check("t6 A out_index",  a_out_index,  32'd0);
      check("t6 A out_count",  a_out_count,  32'd4);
      check("t6 B out_index",  b_out_index,  32'd0);
      idle(2);
    end

    // Long run without in_last: C auto-closes at 64.
    for (int i = 0; i < 70; i++) send_beat(5'($urandom_range(31)), 1'b0, 1'($urandom_range(1)));
    send_beat(5'($urandom_range(31)), 1'b1, 1'b0);
    idle(3);

    // Random frames, gaps and backpressure.
    rand_rdy = 1'b1;
    for (int f = 0; f < 300; f++) begin
      int len;
      len = $urandom_range(12, 1);
      for (int i = 0; i < len; i++) begin
        send_beat(5'($urandom_range(31)), (i == len - 1), 1'($urandom_range(1)));
        idle($urandom_range(2));
      end
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    idle(5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
